// File: rtl/output_ctrl_if.sv
// Router output-port bundle: internal request/grant side plus outbound link.
// The slave modport is the output controller; the master modport drives it.
interface output_ctrl_if #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_IN     = 4
);
  logic [NUM_IN-1:0]            sig_req_channel;
  logic [NUM_IN*DATA_WIDTH-1:0] inner_dataI;
  logic [NUM_IN-1:0]            sig_channel_clean;
  logic                         receiveO;
  logic                         sendO;
  logic [DATA_WIDTH-1:0]        dataO;

  modport master (
    output sig_req_channel,
    output inner_dataI,
    output receiveO,
    input  sig_channel_clean,
    input  sendO,
    input  dataO
  );

  modport slave (
    input  sig_req_channel,
    input  inner_dataI,
    input  receiveO,
    output sig_channel_clean,
    output sendO,
    output dataO
  );
endinterface

// File: rtl/output_ctrl.sv
// Even/odd VC output controller: round-robin grant into the phase's VC FIFO, drain the other.
// Define OUTPUT_CTRL_STATS_EN to add the 16-bit flit_cnt send counter port.
module output_ctrl #(
  parameter int DATA_WIDTH   = 64,
  parameter int BUFFER_DEPTH = 1,
  parameter int NUM_IN       = 4
) (
  input  logic           clk,
  input  logic           rst,
  output_ctrl_if.slave   bus
`ifdef OUTPUT_CTRL_STATS_EN
  ,
  output logic [15:0]    flit_cnt
`endif
);

  localparam int PTRW  = $clog2(NUM_IN);
  localparam int PW    = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int CW    = $clog2(BUFFER_DEPTH + 1);
  localparam int MEM_D = 2 ** PW;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    ODD  = 3'b010,
    EVEN = 3'b100
  } phase_e;

  phase_e phase_q, phase_d;

  always_ff @(posedge clk) begin
    if (rst) phase_q <= IDLE;
    else     phase_q <= phase_d;
  end

  always_comb begin
    phase_d = IDLE;
    case (phase_q)
      IDLE:    phase_d = ODD;
      ODD:     phase_d = EVEN;
      EVEN:    phase_d = ODD;
      default: phase_d = IDLE;
    endcase
  end

  logic active;
  logic wsel;
  logic rsel;

  // VC index 0 = even FIFO, 1 = odd FIFO
  assign active = !rst && (phase_q == ODD || phase_q == EVEN);
  assign wsel   = (phase_q == EVEN) ? 1'b0 : 1'b1;
  assign rsel   = ~wsel;

  logic [DATA_WIDTH-1:0] mem [2][MEM_D];
  logic [PW-1:0]         wp  [2];
  logic [PW-1:0]         rp  [2];
  logic [CW-1:0]         cnt [2];
  logic [1:0]            full;
  logic [1:0]            empty;

  always_comb begin
    for (int v = 0; v < 2; v++) begin
      full[v]  = (cnt[v] == CW'(BUFFER_DEPTH));
      empty[v] = (cnt[v] == '0);
    end
  end

  logic [PTRW-1:0]   rr_ptr;
  logic [PTRW-1:0]   gnt_idx;
  logic [PTRW-1:0]   k;
  logic [NUM_IN-1:0] grant;
  logic              found;

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = rr_ptr;
    if (active && !full[wsel]) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (!found && bus.sig_req_channel[k]) begin
          found    = 1'b1;
          grant[k] = 1'b1;
          gnt_idx  = k;
        end
        k = (k == PTRW'(NUM_IN - 1)) ? '0 : k + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (found) begin
      rr_ptr <= (gnt_idx == PTRW'(NUM_IN - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  logic [DATA_WIDTH-1:0] wr_data;
  logic [1:0]            we;
  logic [1:0]            re;
  logic                  send;

  assign wr_data = bus.inner_dataI[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
  assign send    = active && !empty[rsel] && bus.receiveO;

  always_comb begin
    we       = '0;
    re       = '0;
    we[wsel] = found;
    re[rsel] = send;
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUFFER_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage is rounded up to a power of two; pointers never reach the spare slots
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < 2; v++) begin
        wp[v]  <= '0;
        rp[v]  <= '0;
        cnt[v] <= '0;
      end
    end else begin
      for (int v = 0; v < 2; v++) begin
        if (we[v]) begin
          mem[v][wp[v]] <= wr_data;
          wp[v]         <= ptr_inc(wp[v]);
        end
        if (re[v]) rp[v] <= ptr_inc(rp[v]);
        cnt[v] <= cnt[v] + CW'(we[v]) - CW'(re[v]);
      end
    end
  end

  assign bus.sig_channel_clean = grant;
  assign bus.sendO             = send;
  assign bus.dataO             = send ? mem[rsel][rp[rsel]] : '0;

`ifdef OUTPUT_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)       flit_cnt <= '0;
    else if (send) flit_cnt <= flit_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_output_ctrl.sv
// Bench for output_ctrl: directed vector table, then random traffic vs a queue model.
// Define OUTPUT_CTRL_STATS_EN to also exercise the flit_cnt wrap.
module tb_output_ctrl;

  localparam int DW    = 64;
  localparam int NI    = 4;
  localparam int DEPTH = 1;

  localparam logic [63:0] D0 = 64'hC0DE_0000_0000_0000;
  localparam logic [63:0] D1 = 64'hC0DE_0000_0000_0001;
  localparam logic [63:0] D2 = 64'hA5A5_0000_0000_0001;
  localparam logic [63:0] D3 = 64'hC0DE_0000_0000_0003;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  output_ctrl_if #(.DATA_WIDTH(DW), .NUM_IN(NI)) bus ();

`ifdef OUTPUT_CTRL_STATS_EN
  logic [15:0] flit_cnt;
`endif

  output_ctrl #(
    .DATA_WIDTH  (DW),
    .BUFFER_DEPTH(DEPTH),
    .NUM_IN      (NI)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus)
`ifdef OUTPUT_CTRL_STATS_EN
    ,
    .flit_cnt(flit_cnt)
`endif
  );

  typedef struct {
    logic        r;
    logic [3:0]  req;
    logic        rv;
    logic [3:0]  g;
    logic        s;
    logic [63:0] d;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [63:0] q_even[$];
  logic [63:0] q_odd[$];
  int          rr  = 0;
  int          cyc = 0;
  logic [15:0] cnt = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] rq,
                       input logic rv, input logic [255:0] d);
    @(negedge clk);
    rst                 = r;
    bus.sig_req_channel = rq;
    bus.receiveO        = rv;
    bus.inner_dataI     = d;
    #1;
  endtask

  // phase of a cycle: 0 after reset is idle, odd count = ODD, even = EVEN
  task automatic step(input logic r, input logic [3:0] rq,
                      input logic rv, input logic [255:0] d);
    logic [3:0]  eg;
    logic        es;
    logic [63:0] ed;
    logic        wodd;
    int          gk;
    int          k;
    drive(r, rq, rv, d);
    eg   = '0;
    es   = 1'b0;
    ed   = '0;
    gk   = -1;
    wodd = (cyc % 2 == 1);
    if (!r && cyc != 0) begin
      if ((wodd ? q_odd.size() : q_even.size()) < DEPTH)
        for (int i = 0; i < NI; i++) begin
          k = (rr + i) % NI;
          if (gk < 0 && rq[k]) gk = k;
        end
      if (gk >= 0) eg[gk] = 1'b1;
      if (rv && (wodd ? q_even.size() : q_odd.size()) > 0) begin
        es = 1'b1;
        ed = wodd ? q_even[0] : q_odd[0];
      end
    end
    chk("grant", 64'(bus.sig_channel_clean), 64'(eg));
    chk("sendO", 64'(bus.sendO), 64'(es));
    chk("dataO", bus.dataO, ed);
`ifdef OUTPUT_CTRL_STATS_EN
    if (!r) chk("flit_cnt", 64'(flit_cnt), 64'(cnt));
`endif
    if (r) begin
      q_even.delete();
      q_odd.delete();
      rr  = 0;
      cyc = 0;
      cnt = '0;
    end else begin
      if (es) begin
        if (wodd) void'(q_even.pop_front());
        else      void'(q_odd.pop_front());
      end
      if (gk >= 0) begin
        if (wodd) q_odd.push_back(d[gk*DW +: DW]);
        else      q_even.push_back(d[gk*DW +: DW]);
        rr = (gk + 1) % NI;
      end
      cnt = cnt + 16'(es);
      cyc++;
    end
  endtask

  function automatic logic [255:0] rnd_data();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    vec_t         tv[$];
    logic [255:0] tdata;
    logic         r;
    int           guard;

    tdata = {D3, D2, D1, D0};
    bus.sig_req_channel = '0;
    bus.receiveO        = 1'b0;
    bus.inner_dataI     = '0;

    tv.push_back('{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 64'h0});
    tv.push_back('{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 64'h0});
    tv.push_back('{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 64'h0});
    tv.push_back('{1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0, 64'h0});
    tv.push_back('{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, 64'h0});
    tv.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, D2});
    tv.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 64'h0});
    tv.push_back('{1'b0, 4'b1000, 1'b1, 4'b1000, 1'b0, 64'h0});
    tv.push_back('{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, D3});
    tv.push_back('{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, D0});
    tv.push_back('{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, D1});
    tv.push_back('{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, D2});
    tv.push_back('{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, D3});
    tv.push_back('{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, D0});
    tv.push_back('{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, D1});
    tv.push_back('{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, D2});
    tv.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, D3});
    tv.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 64'h0});
    tv.push_back('{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0, 64'h0});
    tv.push_back('{1'b0, 4'b1111, 1'b0, 4'b0010, 1'b0, 64'h0});
    tv.push_back('{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 64'h0});
    tv.push_back('{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 64'h0});
    tv.push_back('{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b1, D1});
    tv.push_back('{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, D0});
    tv.push_back('{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, D2});
    tv.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, D3});
    tv.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 64'h0});
    tv.push_back('{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b0, 64'h0});
    tv.push_back('{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 64'h0});
    tv.push_back('{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 64'h0});
    tv.push_back('{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b0, 64'h0});
    tv.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, D0});

    foreach (tv[i]) begin
      drive(tv[i].r, tv[i].req, tv[i].rv, tdata);
      chk($sformatf("vec%0d_grant", i), 64'(bus.sig_channel_clean),
          64'(tv[i].g));
      chk($sformatf("vec%0d_sendO", i), 64'(bus.sendO), 64'(tv[i].s));
      chk($sformatf("vec%0d_dataO", i), bus.dataO, tv[i].d);
    end

    step(1'b1, 4'b0000, 1'b1, '0);
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 99) == 0);
      step(r, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
           rnd_data());
    end

`ifdef OUTPUT_CTRL_STATS_EN
    guard = 0;
    while (cnt != 16'hFFFF && guard < 70000) begin
      step(1'b0, 4'hF, 1'b1, rnd_data());
      guard++;
    end
    step(1'b0, 4'hF, 1'b1, rnd_data());
    step(1'b0, 4'hF, 1'b1, rnd_data());
    step(1'b0, 4'hF, 1'b1, rnd_data());
`else
    guard = 0;
    step(1'b0, 4'($urandom_range(0, 15)), 1'b1, rnd_data());
    guard++;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
